// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128/192/256 encryption core, one round per clock
// Optional debug ports dbg_round/dbg_state are added when AES_ENC_DBG_EN is defined.
module aes_encrypt_core #(
  parameter int NK = 8,
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NK*32-1:0]  key,
  input  logic [127:0]      plaintext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      ciphertext,
  output logic              busy
`ifdef AES_ENC_DBG_EN
  ,
  output logic [3:0]        dbg_round,
  output logic [1:0]        dbg_state
`endif
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_encrypt_core: NK must be 4, 6 or 8");
  end
  if (NB != 4) begin : g_bad_nb
    $error("aes_encrypt_core: NB must be 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t               state_q, state_d;
  logic [127:0]         st;
  logic [NK*32-1:0]     key_q;
  logic [3:0]           rnd;
  logic [31:0]          w [0:NW-1];
  logic [127:0]         rk [0:NR];
  logic [31:0]          kx_tmp;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int idx);
    case (idx)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        r[127-8*(4*c+j) -: 8] = s[127-8*(4*((c+j)%4)+j) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Full schedule is combinational from the captured key only.
  always_comb begin
    kx_tmp = '0;
    for (int i = 0; i < NK; i++) w[i] = key_q[32*(NK-1-i) +: 32];
    for (int i = NK; i < NW; i++) begin
      kx_tmp = w[i-1];
      if (i % NK == 0)
        kx_tmp = sub_word({kx_tmp[23:0], kx_tmp[31:24]}) ^ {rcon(i / NK), 24'h0};
      else if (NK > 6 && i % NK == 4)
        kx_tmp = sub_word(kx_tmp);
      w[i] = w[i-NK] ^ kx_tmp;
    end
  end

  always_comb begin
    for (int j = 0; j <= NR; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)             state_d = ROUND;
      ROUND:   if (rnd == 4'(NR - 1))    state_d = FINAL;
      FINAL:                             state_d = DONE;
      DONE:    if (out_ready)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      ROUND:   busy      = 1'b1;
      FINAL:   busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= '0;
      key_q      <= '0;
      rnd        <= '0;
      ciphertext <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          key_q <= key;
          st    <= plaintext ^ key[NK*32-1 -: 128];
          rnd   <= 4'd1;
        end
        ROUND: begin
          st  <= mix_columns(shift_rows(sub_bytes(st))) ^ rk[rnd];
          rnd <= rnd + 4'd1;
        end
        FINAL: ciphertext <= shift_rows(sub_bytes(st)) ^ rk[NR];
        default: ;
      endcase
    end
  end

`ifdef AES_ENC_DBG_EN
  assign dbg_round = rnd;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - randomized self-checking bench for aes_encrypt_core (NK=4/6/8)
module tb_aes_encrypt_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_bus;
  logic [127:0] pt;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ct0, ct1, ct2;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];

  always #5 clk = ~clk;

  aes_encrypt_core #(.NK(4)) u_nk4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .key(key_bus[255:128]), .plaintext(pt), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .ciphertext(ct0), .busy(busy[0]));
  aes_encrypt_core #(.NK(6)) u_nk6 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .key(key_bus[255:64]), .plaintext(pt), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .ciphertext(ct1), .busy(busy[1]));
  aes_encrypt_core #(.NK(8)) u_nk8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .key(key_bus), .plaintext(pt), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .ciphertext(ct2), .busy(busy[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ct_of(input int idx);
    case (idx)
      0:       return ct0;
      1:       return ct1;
      default: return ct2;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (v != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      sb[v] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      isb[sb[v]] = x;
    end
  endtask

  function automatic logic [127:0] round_key(input int nk, input logic [255:0] k, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] t_sub(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] t_shift(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c + (inv ? 4-r : r)) % 4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] t_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-r+4)%4], s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] mdl_enc(input int nk, input logic [255:0] k, input logic [127:0] p);
    logic [127:0] s;
    s = p ^ round_key(nk, k, 0);
    for (int r = 1; r < nk + 6; r++) s = t_mix(t_shift(t_sub(s, 0), 0), 0) ^ round_key(nk, k, r);
    return t_shift(t_sub(s, 0), 0) ^ round_key(nk, k, nk + 6);
  endfunction

  function automatic logic [127:0] mdl_dec(input int nk, input logic [255:0] k, input logic [127:0] c);
    logic [127:0] s;
    s = c ^ round_key(nk, k, nk + 6);
    for (int r = nk + 5; r >= 1; r--) s = t_mix(t_sub(t_shift(s, 1), 1) ^ round_key(nk, k, r), 1);
    return t_sub(t_shift(s, 1), 1) ^ round_key(nk, k, 0);
  endfunction

  task automatic run_block(input int idx, input logic [255:0] k, input logic [127:0] p,
                           input int hold, input bit perturb, input bit poke,
                           output logic [127:0] got);
    int           nk = 4 + 2*idx;
    int           lat = 0;
    bit           stable = 1'b1;
    logic [127:0] exp;
    exp = mdl_enc(nk, k, p);
    @(negedge clk);
    key_bus = k; pt = p; out_ready[idx] = (hold == 0); in_valid[idx] = 1'b1;
    check($sformatf("in_ready_idle_nk%0d", nk), in_ready[idx], 1);
    @(posedge clk); @(negedge clk);
    in_valid[idx] = 1'b0;
    check($sformatf("busy_nk%0d", nk), busy[idx], 1);
    while (!out_valid[idx] && lat < 40) begin
      if (perturb) begin key_bus = {8{$urandom}}; pt = {4{$urandom}}; end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check($sformatf("latency_nk%0d", nk), lat, nk + 6);
    got = ct_of(idx);
    check($sformatf("ct_nk%0d", nk), got, exp);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin in_valid[idx] = 1'b1; key_bus = {8{$urandom}}; pt = {4{$urandom}}; end
      @(posedge clk); @(negedge clk);
      if (ct_of(idx) !== got || in_ready[idx] || !out_valid[idx]) stable = 1'b0;
    end
    if (hold > 0) check($sformatf("backpressure_hold_nk%0d", nk), stable, 1);
    in_valid[idx] = 1'b0; out_ready[idx] = 1'b1;
    @(posedge clk); @(negedge clk);
    check($sformatf("idle_after_handshake_nk%0d", nk), {in_ready[idx], out_valid[idx], busy[idx]}, 3'b100);
  endtask

  localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_SEQ  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] got;
    logic [127:0] kat [3];
    logic [255:0] rk_key;
    logic [127:0] rp;
    bit           seen;
    int           idx;
    kat[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    kat[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    kat[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    build_tables();
    rst = 1'b1; in_valid = '0; out_ready = 3'b111; key_bus = '0; pt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ctl_%0d", i), {in_ready[i], out_valid[i], busy[i]}, 3'b100);
      check($sformatf("reset_ct_%0d", i), ct_of(i), 128'h0);
    end
    rst = 1'b0;

    rk_key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    run_block(0, rk_key, 128'h3243f6a8885a308d313198a2e0370734, 0, 0, 0, got);
    check("kat_fips_nk4", got, 128'h3925841d02dc09fbdc118597196a0b32);
    check("loopback_fips_nk4", mdl_dec(4, rk_key, got), 128'h3243f6a8885a308d313198a2e0370734);

    for (int i = 0; i < 3; i++) begin
      run_block(i, KEY_SEQ, PT_SEQ, 0, 0, 0, got);
      check($sformatf("kat_seq_nk%0d", 4 + 2*i), got, kat[i]);
      check($sformatf("loopback_seq_nk%0d", 4 + 2*i), mdl_dec(4 + 2*i, KEY_SEQ, got), PT_SEQ);
    end

    run_block(1, {8{$urandom}}, {4{$urandom}}, 20, 0, 1, got);

    @(negedge clk);
    key_bus = KEY_SEQ; pt = PT_SEQ; in_valid[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid[2] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_ctl", {in_ready[2], out_valid[2], busy[2]}, 3'b100);
    check("abort_ct", ct2, 128'h0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (out_valid[2]) seen = 1'b1;
    end
    check("abort_no_output", seen, 0);
    run_block(2, KEY_SEQ, PT_SEQ, 0, 0, 0, got);
    check("kat_after_abort_nk8", got, kat[2]);

    run_block(2, {8{$urandom}}, {4{$urandom}}, 0, 1, 0, got);

    for (int n = 0; n < 8; n++) begin
      idx = int'($urandom_range(0, 2));
      rk_key = {8{$urandom}};
      rp = {4{$urandom}};
      run_block(idx, rk_key, rp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, got);
      check("rand_loopback", mdl_dec(4 + 2*idx, rk_key, got), rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
